joint_position_ctrl: RTL

Closed-loop position controller for one robotic-arm joint. Integrates the one-cycle `cw`/`ccw` full-step pulses from the joint's quadrature encoder decoder into a signed position. Accepts target positions over a valid/ready command port and sequences the joint's motor enable/direction outputs through MOVE, SETTLE and FAULT phases, with stall detection and abort. Sits between the arm command sequencer (upstream) and the encoder decoder plus motor driver (downstream).

---
 rtl/joint_position_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/joint_position_ctrl.sv
// joint_position_ctrl: encoder-integrating position loop sequencing motor enable/direction through MOVE, SETTLE and FAULT
module joint_position_ctrl #(
  parameter int POS_W         = 16,
  parameter int DEADBAND      = 2,
  parameter int SETTLE_CYCLES = 1024,
  parameter int STALL_CYCLES  = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cw,
  input  logic                    ccw,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [POS_W-1:0] cmd_target,
  input  logic                    zero,
  input  logic                    abort,
  output logic                    motor_en,
  output logic                    motor_dir,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    done,
  output logic                    fault
);
  localparam int SW = $clog2(STALL_CYCLES);
  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic signed [POS_W-1:0] P_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] P_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [POS_W:0] DB = (POS_W+1)'(DEADBAND);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SETTLE, S_FAULT} state_t;

  state_t                  r_state, w_state_n;
  logic signed [POS_W-1:0] r_pos, w_pos_n, r_target, w_target_n;
  logic signed [POS_W:0]   w_err;
  logic [SW-1:0]           r_stall, w_stall_n;
  logic [TW-1:0]           r_settle, w_settle_n;
  logic                    r_en, w_en_n, r_dir, w_dir_n, r_done, w_done_n;
  logic                    w_pulse, w_in_band;

  assign w_pulse   = cw | ccw;
  // one extra bit so the difference of two extreme positions cannot overflow
  assign w_err     = {r_target[POS_W-1], r_target} - {r_pos[POS_W-1], r_pos};
  assign w_in_band = (w_err <= DB) && (w_err >= -DB);
  assign w_pos_n   = (r_state == S_IDLE && zero) ? '0 :
                     (cw && !ccw && r_pos != P_MAX) ? r_pos + POS_W'(1) :
                     (ccw && !cw && r_pos != P_MIN) ? r_pos - POS_W'(1) : r_pos;

  always_comb begin
    w_state_n  = r_state;
    w_target_n = r_target;
    w_stall_n  = r_stall;
    w_settle_n = r_settle;
    w_en_n     = 1'b0;
    w_dir_n    = r_dir;
    w_done_n   = 1'b0;
    case (r_state)
      S_IDLE: if (cmd_valid) begin
        w_state_n  = S_MOVE;
        w_target_n = cmd_target;
        w_stall_n  = '0;
        w_settle_n = '0;
      end
      S_MOVE: begin
        w_stall_n = w_pulse ? '0 : r_stall + SW'(1);
        if (abort) w_state_n = S_IDLE;
        else if (r_stall == STALL_LAST && !w_pulse) w_state_n = S_FAULT;
        else if (w_in_band) begin
          w_state_n  = S_SETTLE;
          w_settle_n = '0;
        end else begin
          w_en_n  = 1'b1;
          w_dir_n = !w_err[POS_W] && (w_err != '0);
        end
      end
      S_SETTLE: begin
        if (abort) w_state_n = S_IDLE;
        else if (!w_in_band) begin
          w_state_n = S_MOVE;
          w_stall_n = '0;
        end else if (r_settle == SETTLE_LAST) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end else w_settle_n = r_settle + TW'(1);
      end
      S_FAULT: if (abort) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pos    <= '0;
      r_target <= '0;
      r_stall  <= '0;
      r_settle <= '0;
      r_en     <= 1'b0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_pos    <= w_pos_n;
      r_target <= w_target_n;
      r_stall  <= w_stall_n;
      r_settle <= w_settle_n;
      r_en     <= w_en_n;
      r_dir    <= w_dir_n;
      r_done   <= w_done_n;
    end
  end

  assign cmd_ready = r_state == S_IDLE;
  assign busy      = r_state != S_IDLE;
  assign fault     = r_state == S_FAULT;
  assign motor_en  = r_en;
  assign motor_dir = r_dir;
  assign position  = r_pos;
  assign done      = r_done;
endmodule
